// File: rtl/player_move_ctrl_if.sv
// rtl/player_move_ctrl_if.sv - blocked-tile query bus between a movement controller and the map store
interface player_move_ctrl_if;
  logic       q_valid;
  logic [3:0] q_col;
  logic [3:0] q_row;
  logic       q_ack;
  logic       q_blocked;

  modport master (
    output q_valid,
    output q_col,
    output q_row,
    input  q_ack,
    input  q_blocked
  );

  modport slave (
    input  q_valid,
    input  q_col,
    input  q_row,
    output q_ack,
    output q_blocked
  );
endinterface

// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - grid-aligned, tick-paced player movement with blocked-tile query
module player_move_ctrl #(
  parameter int TILE      = 48,
  parameter int STEP      = 4,
  parameter int GRID_COLS = 13,
  parameter int GRID_ROWS = 10,
  parameter int START_COL = 1,
  parameter int START_ROW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  player_move_ctrl_if.master  qbus,
  output logic [9:0]          p_x,
  output logic [9:0]          p_y,
  output logic [3:0]          tile_col,
  output logic [3:0]          tile_row,
  output logic                moving,
  output logic [1:0]          facing
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_QUERY = 2'd1,
    S_MOVE  = 2'd2
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [9:0] TILE_PX   = 10'(TILE);
  localparam logic [9:0] STEP_PX   = 10'(STEP);
  localparam logic [5:0] TILE_REM  = 6'(TILE);
  localparam logic [5:0] STEP_REM  = 6'(STEP);
  localparam logic [3:0] LAST_COL  = 4'(GRID_COLS - 1);
  localparam logic [3:0] LAST_ROW  = 4'(GRID_ROWS - 1);
  localparam logic [3:0] RST_COL   = 4'(START_COL);
  localparam logic [3:0] RST_ROW   = 4'(START_ROW);
  localparam logic [9:0] RST_PX    = 10'(START_COL * TILE);
  localparam logic [9:0] RST_PY    = 10'(START_ROW * TILE);

  state_t     state_q, state_d;
  logic [9:0] p_x_q, p_x_d;
  logic [9:0] p_y_q, p_y_d;
  logic [3:0] tile_col_q, tile_col_d;
  logic [3:0] tile_row_q, tile_row_d;
  logic       q_valid_q, q_valid_d;
  logic [3:0] q_col_q, q_col_d;
  logic [3:0] q_row_q, q_row_d;
  logic       moving_q, moving_d;
  logic [1:0] facing_q, facing_d;
  logic [5:0] rem_q, rem_d;

  logic       dir_hit;
  logic [1:0] dir_sel;
  logic [3:0] tgt_col;
  logic [3:0] tgt_row;
  logic       tgt_ok;

  // Pick the highest-priority pressed button (up > down > left > right).
  always_comb begin
    dir_hit = 1'b1;
    dir_sel = DIR_DOWN;
    if (btn_up)         dir_sel = DIR_UP;
    else if (btn_down)  dir_sel = DIR_DOWN;
    else if (btn_left)  dir_sel = DIR_LEFT;
    else if (btn_right) dir_sel = DIR_RIGHT;
    else                dir_hit = 1'b0;
  end

  // Neighbouring tile in the chosen direction and whether it lies on the playfield.
  always_comb begin
    tgt_col = tile_col_q;
    tgt_row = tile_row_q;
    tgt_ok  = 1'b0;
    case (dir_sel)
      DIR_UP: begin
        tgt_ok  = (tile_row_q != 4'd0);
        tgt_row = tile_row_q - 4'd1;
      end
      DIR_DOWN: begin
        tgt_ok  = (tile_row_q < LAST_ROW);
        tgt_row = tile_row_q + 4'd1;
      end
      DIR_LEFT: begin
        tgt_ok  = (tile_col_q != 4'd0);
        tgt_col = tile_col_q - 4'd1;
      end
      default: begin
        tgt_ok  = (tile_col_q < LAST_COL);
        tgt_col = tile_col_q + 4'd1;
      end
    endcase
  end

  // Next-state logic for the IDLE -> QUERY -> MOVE cycle.
  always_comb begin
    state_d    = state_q;
    p_x_d      = p_x_q;
    p_y_d      = p_y_q;
    tile_col_d = tile_col_q;
    tile_row_d = tile_row_q;
    q_valid_d  = q_valid_q;
    q_col_d    = q_col_q;
    q_row_d    = q_row_q;
    moving_d   = moving_q;
    facing_d   = facing_q;
    rem_d      = rem_q;
    case (state_q)
      S_IDLE: begin
        if (tick && dir_hit) begin
          facing_d = dir_sel;
          if (tgt_ok) begin
            q_col_d   = tgt_col;
            q_row_d   = tgt_row;
            q_valid_d = 1'b1;
            state_d   = S_QUERY;
          end
        end
      end
      S_QUERY: begin
        // Ticks are dropped here, so an ack coinciding with a tick never steps the sprite.
        if (q_valid_q && qbus.q_ack) begin
          q_valid_d = 1'b0;
          if (qbus.q_blocked) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_MOVE;
            rem_d    = TILE_REM;
            moving_d = 1'b1;
          end
        end
      end
      S_MOVE: begin
        if (tick) begin
          case (facing_q)
            DIR_UP:   p_y_d = p_y_q - STEP_PX;
            DIR_DOWN: p_y_d = p_y_q + STEP_PX;
            DIR_LEFT: p_x_d = p_x_q - STEP_PX;
            default:  p_x_d = p_x_q + STEP_PX;
          endcase
          rem_d = rem_q - STEP_REM;
          // Final step snaps to the exact tile origin so pixel and tile state agree.
          if (rem_q == STEP_REM) begin
            tile_col_d = q_col_q;
            tile_row_d = q_row_q;
            p_x_d      = {6'd0, q_col_q} * TILE_PX;
            p_y_d      = {6'd0, q_row_q} * TILE_PX;
            moving_d   = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset lands the sprite on its spawn tile facing down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      p_x_q      <= RST_PX;
      p_y_q      <= RST_PY;
      tile_col_q <= RST_COL;
      tile_row_q <= RST_ROW;
      q_valid_q  <= 1'b0;
      q_col_q    <= 4'd0;
      q_row_q    <= 4'd0;
      moving_q   <= 1'b0;
      facing_q   <= DIR_DOWN;
      rem_q      <= 6'd0;
    end else begin
      state_q    <= state_d;
      p_x_q      <= p_x_d;
      p_y_q      <= p_y_d;
      tile_col_q <= tile_col_d;
      tile_row_q <= tile_row_d;
      q_valid_q  <= q_valid_d;
      q_col_q    <= q_col_d;
      q_row_q    <= q_row_d;
      moving_q   <= moving_d;
      facing_q   <= facing_d;
      rem_q      <= rem_d;
    end
  end

  assign qbus.q_valid = q_valid_q;
  assign qbus.q_col   = q_col_q;
  assign qbus.q_row   = q_row_q;
  assign p_x          = p_x_q;
  assign p_y          = p_y_q;
  assign tile_col     = tile_col_q;
  assign tile_row     = tile_row_q;
  assign moving       = moving_q;
  assign facing       = facing_q;

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Per-player movement controller. Turns the direction buttons into grid-aligned, pixel-smooth motion of the player sprite.
- Produces the sprite's top-left pixel position (p_x horizontal, p_y vertical), which feeds the character painter directly.
- Before each move it asks the map/block store whether the target tile is blocked, over a valid/ack handshake.
- One instance per player.

Parameters:
- TILE, 48, tile edge in pixels.
- STEP, 4, pixels advanced per frame tick; must divide TILE.
- GRID_COLS, 13, playfield columns (0..GRID_COLS-1).
- GRID_ROWS, 10, playfield rows (0..GRID_ROWS-1).
- START_COL, 1, spawn column.
- START_ROW, 1, spawn row.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle pulse per frame (vsync-derived); all motion is paced by it.
- btn_up  in  1  synchronized, debounced level.
- btn_down  in  1  synchronized, debounced level.
- btn_left  in  1  synchronized, debounced level.
- btn_right  in  1  synchronized, debounced level.
- q_valid  out  1  blocked-tile query request.
- q_col  out  4  queried column.
- q_row  out  4  queried row.
- q_ack  in  1  query response strobe.
- q_blocked  in  1  response data, valid when q_ack=1.
- p_x  out  10  sprite top-left x pixel.
- p_y  out  10  sprite top-left y pixel.
- tile_col  out  4  current/committed column.
- tile_row  out  4  current/committed row.
- moving  out  1  high while in MOVE.
- facing  out  2  direction: 0 up, 1 down, 2 left, 3 right.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-low (rst_n); it fully overrides any state, including mid-query and mid-move.
- Reset values:
  - state = IDLE.
  - tile_col = START_COL, tile_row = START_ROW.
  - p_x = START_COL*TILE, p_y = START_ROW*TILE.
  - q_valid = 0, q_col/q_row = 0, moving = 0, facing = 1 (down).
- FSM states: IDLE, QUERY, MOVE.
- IDLE:
  - Buttons are sampled only in a cycle with tick=1.
  - Priority: up > down > left > right. If none is pressed, stay in IDLE.
  - On a pressed direction, facing updates in that cycle.
  - Target tile = current tile ±1 in that direction.
  - If the target is outside 0..GRID_COLS-1 or 0..GRID_ROWS-1: stay in IDLE, no query.
  - Otherwise: latch the target into q_col/q_row, set q_valid=1 from the next cycle, go to QUERY.
- QUERY:
  - q_valid, q_col and q_row are held stable until q_ack=1. Latency is unbounded; no timeout.
  - tick is ignored in this state.
  - In the ack cycle, q_valid drops at the next edge.
  - q_blocked=1: return to IDLE, position unchanged, facing kept.
  - q_blocked=0: go to MOVE, load remaining = TILE, moving = 1.
  - A q_ack seen while q_valid=0 is ignored.
- MOVE:
  - On each tick, p_x or p_y changes by STEP in the facing direction (up: p_y-STEP, down: p_y+STEP, left: p_x-STEP, right: p_x+STEP) and remaining -= STEP.
  - On the tick where remaining reaches 0:
    - tile_col/tile_row commit to the target.
    - p_x = tile_col*TILE, p_y = tile_row*TILE exactly.
    - moving = 0, next state IDLE.
  - Buttons are ignored during MOVE. A new move needs a later tick in IDLE, so the earliest chained move starts on the tick after the completing tick.
  - A move takes exactly TILE/STEP ticks.
- Arithmetic: 10-bit unsigned. The bounds check guarantees no underflow or overflow. remaining is 6 bits.
- Simultaneous events:
  - tick and q_ack in the same cycle while in QUERY: the ack is processed and the tick is dropped.
  - Opposing buttons resolve by priority (up+down → up).

Test Plan:
- Reset with defaults → p_x=48, p_y=48, tile=(1,1), q_valid=0, facing=1, moving=0. Assert rst_n low mid-MOVE → the same values return immediately, without waiting for a clk edge.
- btn_right held, tick, ack with q_blocked=0 three cycles later → q_col=2, q_row=1 held stable until ack. Then 12 ticks, p_x = 52,56,…,96. Then tile=(2,1), moving=0.
- btn_up, target (1,0) → query issued, ack with q_blocked=1 → p_y stays 48, facing=0, state back to IDLE, q_valid=0 the cycle after ack.
- Move to (0,1), then btn_left + tick → no query (off grid), facing=2, position unchanged. Repeat with row 9 + btn_down.
- btn_up and btn_down pressed together + tick → q_row=0 (up wins). tick coincident with q_ack → no pixel step in that cycle; the first step comes on the next tick.
- btn_right held continuously → two consecutive moves, separated by exactly one idle tick. Final p_x=144, tile_col=3.
